// File: rtl/arbitro_sumador_pkg.sv
// Shared types and constants for the round-robin arbitrated adder.
package arbitro_sumador_pkg;

  localparam int WIDTH = 32;
  localparam int N_REQ = 3;

  // Requester 2 is taken as the last one served, so requester 0 has first priority.
  localparam logic [1:0] LAST_RESET = 2'd2;

  typedef enum logic {
    LIBRE   = 1'b0,
    OCUPADO = 1'b1
  } estado_t;

  // Round-robin pick: the search starts one past the last grant and wraps 2 -> 0.
  function automatic logic [N_REQ-1:0] rr_grant(input logic [N_REQ-1:0] elig,
                                                input logic [1:0]       last);
    logic [N_REQ-1:0] gnt;
    logic             found;
    logic [1:0]       idx;
    gnt   = '0;
    found = 1'b0;
    for (int s = 1; s <= N_REQ; s++) begin
      idx = 2'((int'(last) + s) % N_REQ);
      if (!found && elig[idx]) begin
        gnt[idx] = 1'b1;
        found    = 1'b1;
      end
    end
    return gnt;
  endfunction

  // Index of a one-hot grant. An empty mask gives 0, but callers only use it when a grant exists.
  function automatic logic [1:0] onehot_idx(input logic [N_REQ-1:0] oh);
    logic [1:0] idx;
    idx = 2'd0;
    if (oh[1]) idx = 2'd1;
    if (oh[2]) idx = 2'd2;
    return idx;
  endfunction

endpackage

// File: rtl/arbitro_sumador_sumador.sv
// Plain combinational adder. The carry out is dropped, so the result is the sum mod 2^WIDTH.
module arbitro_sumador_sumador
  import arbitro_sumador_pkg::*;
(
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] o
);

  assign o = a + b;

endmodule

// File: rtl/arbitro_sumador.sv
// Three requesters share one adder through a round-robin arbiter.
//
//   state   | meaning
//   --------+-------------------------------------------------------------
//   LIBRE   | idle or acking; grants an eligible requester and latches its operands
//   OCUPADO | the adder works on the latched operands; the result is registered on exit
module arbitro_sumador
  import arbitro_sumador_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  req_i,
  input  logic [31:0] a0_i,
  input  logic [31:0] b0_i,
  input  logic [31:0] a1_i,
  input  logic [31:0] b1_i,
  input  logic [31:0] a2_i,
  input  logic [31:0] b2_i,
  output logic [2:0]  ack_o,
  output logic [31:0] o,
  output logic        ovf_o,
  output logic        ocupado_o
);

  estado_t          state_q, state_d;
  logic [1:0]       last_q, last_d;
  logic [1:0]       owner_q, owner_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [WIDTH-1:0] o_q, o_d;
  logic             ovf_q, ovf_d;
  logic [N_REQ-1:0] ack_q, ack_d;

  logic [N_REQ-1:0] eligible;
  logic [N_REQ-1:0] gnt;
  logic [1:0]       gnt_idx;
  logic [WIDTH-1:0] sum;

  // A requester that is being acked this cycle cannot win again until it re-requests.
  assign eligible = req_i & ~ack_q;
  assign gnt      = rr_grant(eligible, last_q);
  assign gnt_idx  = onehot_idx(gnt);

  arbitro_sumador_sumador u_sumador (
    .a (a_q),
    .b (b_q),
    .o (sum)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= LIBRE;
    else     state_q <= state_d;
  end

  // Datapath and arbitration registers. Reset wins over a grant or a completion in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_q  <= LAST_RESET;
      owner_q <= 2'd0;
      a_q     <= '0;
      b_q     <= '0;
      o_q     <= '0;
      ovf_q   <= 1'b0;
      ack_q   <= '0;
    end else begin
      last_q  <= last_d;
      owner_q <= owner_d;
      a_q     <= a_d;
      b_q     <= b_d;
      o_q     <= o_d;
      ovf_q   <= ovf_d;
      ack_q   <= ack_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      LIBRE:   if (|gnt) state_d = OCUPADO;
      OCUPADO: state_d = LIBRE;
      default: state_d = LIBRE;
    endcase
  end

  // Next values for the datapath: latch operands on a grant, register the result on completion.
  always_comb begin
    last_d  = last_q;
    owner_d = owner_q;
    a_d     = a_q;
    b_d     = b_q;
    o_d     = o_q;
    ovf_d   = ovf_q;
    ack_d   = '0;
    case (state_q)
      LIBRE: begin
        if (|gnt) begin
          last_d  = gnt_idx;
          owner_d = gnt_idx;
          case (gnt_idx)
            2'd0:    begin a_d = a0_i; b_d = b0_i; end
            2'd1:    begin a_d = a1_i; b_d = b1_i; end
            default: begin a_d = a2_i; b_d = b2_i; end
          endcase
        end
      end
      OCUPADO: begin
        o_d   = sum;
        ovf_d = (a_q[WIDTH-1] == b_q[WIDTH-1]) && (sum[WIDTH-1] != a_q[WIDTH-1]);
        ack_d = 3'b001 << owner_q;
      end
      default: ;
    endcase
  end

  // Outputs.
  always_comb begin
    ocupado_o = (state_q == OCUPADO);
    ack_o     = ack_q;
    o         = o_q;
    ovf_o     = ovf_q;
  end

endmodule

// File: tb/tb_arbitro_sumador.sv
// Scoreboard bench for arbitro_sumador: directed vectors push expected acks and sums, and a monitor checks them.
module tb_arbitro_sumador;

  logic        clk;
  logic        rst;
  logic [2:0]  req_i;
  logic [31:0] a0_i, b0_i, a1_i, b1_i, a2_i, b2_i;
  logic [2:0]  ack_o;
  logic [31:0] o;
  logic        ovf_o;
  logic        ocupado_o;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [2:0]  ack;
    logic [31:0] o;
    logic        ovf;
  } exp_t;

  exp_t exp_q[$];

  arbitro_sumador dut (
    .clk       (clk),
    .rst       (rst),
    .req_i     (req_i),
    .a0_i      (a0_i),
    .b0_i      (b0_i),
    .a1_i      (a1_i),
    .b1_i      (b1_i),
    .a2_i      (a2_i),
    .b2_i      (b2_i),
    .ack_o     (ack_o),
    .o         (o),
    .ovf_o     (ovf_o),
    .ocupado_o (ocupado_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, req, $time);
    end
  endtask

  // Whenever the DUT presents an ack, the oldest expectation is popped and compared.
  always @(negedge clk) begin
    if (!rst && ack_o != 3'b000) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack=%b o=0x%08h, expected no ack", ack_o, o);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("ack_order", {29'd0, ack_o}, {29'd0, e.ack});
        chk("sum", o, e.o);
        chk("ovf", {31'd0, ovf_o}, {31'd0, e.ovf});
      end
    end
  end

  // Raise requester k with its operands and record the result it should get back.
  task automatic issue(input int k, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic eovf);
    exp_t e;
    case (k)
      0:       begin a0_i = a; b0_i = b; end
      1:       begin a1_i = a; b1_i = b; end
      default: begin a2_i = a; b2_i = b; end
    endcase
    req_i[k] = 1'b1;
    e.ack = 3'b001 << k;
    e.o   = eo;
    e.ovf = eovf;
    exp_q.push_back(e);
  endtask

  // Requesters drop their request on their ack. Returns once everything is served, or flags a timeout.
  task automatic run_until_idle(input int budget);
    int  n;
    logic idle;
    n    = 0;
    idle = 1'b0;
    while (!idle && n < budget) begin
      @(negedge clk);
      req_i = req_i & ~ack_o;
      n++;
      idle = (req_i == 3'b000) && (ack_o == 3'b000) && !ocupado_o;
    end
    checks++;
    if (!idle) begin
      errors++;
      $display("FAIL timeout: still busy after %0d cycles, expected idle", n);
    end
  endtask

  initial begin
    rst   = 1'b1;
    req_i = 3'b000;
    a0_i = '0; b0_i = '0; a1_i = '0; b1_i = '0; a2_i = '0; b2_i = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ack", {29'd0, ack_o}, 32'd0);
    chk("rst_o", o, 32'd0);
    chk("rst_ovf", {31'd0, ovf_o}, 32'd0);
    chk("rst_ocupado", {31'd0, ocupado_o}, 32'd0);

    // Single requests: positive, negative operand, result going negative.
    issue(0, 32'd1000, 32'd1305, 32'd2305, 1'b0);
    run_until_idle(20);
    issue(1, 32'd387, 32'hFFFF_FF9C, 32'd287, 1'b0);
    run_until_idle(20);
    issue(2, 32'd45, 32'hFFFF_FFCE, 32'hFFFF_FFFB, 1'b0);
    run_until_idle(20);
    chk("o_holds", o, 32'hFFFF_FFFB);

    // Signed overflow in both directions, and a case that does not overflow.
    issue(0, 32'h7FFF_FFFF, 32'd1, 32'h8000_0000, 1'b1);
    run_until_idle(20);
    issue(0, 32'd996, 32'd4, 32'd1000, 1'b0);
    run_until_idle(20);
    issue(1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 1'b1);
    run_until_idle(20);
    issue(2, 32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 1'b1);
    run_until_idle(20);

    // Contention with last grant = 2: expected order is 0, 1, 2, then 0 again after re-request.
    issue(0, 32'd10, 32'd1, 32'd11, 1'b0);
    issue(1, 32'd20, 32'd2, 32'd22, 1'b0);
    issue(2, 32'd30, 32'd3, 32'd33, 1'b0);
    run_until_idle(40);
    issue(0, 32'd100, 32'd1, 32'd101, 1'b0);
    issue(1, 32'd200, 32'd2, 32'd202, 1'b0);
    issue(2, 32'd300, 32'd3, 32'd303, 1'b0);
    run_until_idle(40);

    // Changing an operand while the addition is in flight must not change the result.
    issue(0, 32'd5, 32'd6, 32'd11, 1'b0);
    @(negedge clk);
    chk("ocupado_during_op", {31'd0, ocupado_o}, 32'd1);
    a0_i = 32'd100;
    run_until_idle(20);

    // Reset during OCUPADO aborts the addition; afterwards requester 0 has priority again.
    a1_i  = 32'd7;
    b1_i  = 32'd8;
    req_i = 3'b010;
    @(negedge clk);
    chk("ocupado_before_rst", {31'd0, ocupado_o}, 32'd1);
    rst   = 1'b1;
    req_i = 3'b000;
    @(negedge clk);
    rst = 1'b0;
    chk("abort_ack", {29'd0, ack_o}, 32'd0);
    chk("abort_o", o, 32'd0);
    chk("abort_ovf", {31'd0, ovf_o}, 32'd0);
    chk("abort_ocupado", {31'd0, ocupado_o}, 32'd0);
    repeat (2) @(negedge clk);
    chk("abort_no_late_ack", {29'd0, ack_o}, 32'd0);
    issue(0, 32'd1, 32'd2, 32'd3, 1'b0);
    issue(1, 32'd3, 32'd4, 32'd7, 1'b0);
    run_until_idle(30);

    repeat (2) @(negedge clk);
    chk("scoreboard_drained", exp_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
